// File: rtl/gemm_tile_sequencer.sv
// Splits one GEMM job (M x K x N) into W x W tile commands for the TPU control unit.
// Optional stall counter output is enabled by defining TILE_SEQ_PERF_EN.
module gemm_tile_sequencer #(
  parameter int unsigned ADDR_WIDTH           = 10,
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned OUTST_MAX            = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [7:0]            job_m,
  input  logic [7:0]            job_k,
  input  logic [7:0]            job_n,
  input  logic [ADDR_WIDTH-1:0] job_addr_a,
  input  logic [ADDR_WIDTH-1:0] job_addr_b,
  input  logic [ADDR_WIDTH-1:0] job_addr_c,
  input  logic [ADDR_WIDTH-1:0] job_addr_d,
  output logic                  cmd_valid,
  output logic [63:0]           cmd_data,
  input  logic                  cmd_ready,
  input  logic                  tile_done,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err
`ifdef TILE_SEQ_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  // W is assumed to be a power of two so tile rounding is a mask.
  localparam int unsigned W  = SYSTOLIC_ARRAY_WIDTH;
  localparam int unsigned OW = $clog2(OUTST_MAX + 1);
  localparam logic [8:0]            WL = 9'(W);
  localparam logic [7:0]            W8 = 8'(W);
  localparam logic [ADDR_WIDTH-1:0] WA = ADDR_WIDTH'(W);
  localparam logic [8:0]            WM = 9'(W - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StWaitDep = 3'd2;
  localparam logic [2:0] StDrain   = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  err_q, err_d;
  logic [7:0]            rem_m_q, rem_m_d, rem_n_q, rem_n_d, rem_k_q, rem_k_d;
  logic [7:0]            k_q, k_d, n_q, n_d;
  logic                  kt_nz_q, kt_nz_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, a_row_q, a_row_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d, b_col_q, b_col_d, b_base_q, b_base_d;
  logic [ADDR_WIDTH-1:0] stride_b_q, stride_b_d;
  logic [ADDR_WIDTH-1:0] addr_d_q, addr_d_d, c_run_q, c_run_d;
  logic [OW-1:0]         outst_q, outst_d;

  logic                  hs, dec;
  logic                  last_m, last_n, last_k;
  logic [7:0]            len_m, len_n, len_k;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [8:0]            n_up;

  assign job_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign job_done  = (state_q == StDone);
  assign job_err   = (state_q == StDone) && err_q;
  assign cmd_valid = (state_q == StIssue) && (outst_q != OW'(OUTST_MAX));
  assign hs        = cmd_valid && cmd_ready;
  assign dec       = tile_done && (outst_q != '0);

  // Remaining extent per dimension; the current tile is the last one once it fits in W.
  assign last_m = ({1'b0, rem_m_q} <= WL);
  assign last_n = ({1'b0, rem_n_q} <= WL);
  assign last_k = ({1'b0, rem_k_q} <= WL);
  assign len_m  = last_m ? rem_m_q : W8;
  assign len_n  = last_n ? rem_n_q : W8;
  assign len_k  = last_k ? rem_k_q : W8;
  // K-continuation tiles accumulate onto the partial already in the output buffer.
  assign addr_c = kt_nz_q ? addr_d_q : c_run_q;

  assign cmd_data = {addr_d_q, addr_c, addr_b_q, addr_a_q, len_n, len_k, len_m};

  // Row stride of B between K tiles is NT*W, i.e. N rounded up to a multiple of W.
  assign n_up = ({1'b0, job_n} + WM) & ~WM;

  always_comb begin
    outst_d = outst_q;
    if (hs && !dec) begin
      outst_d = outst_q + OW'(1);
    end else if (!hs && dec) begin
      outst_d = outst_q - OW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    rem_m_d    = rem_m_q;
    rem_n_d    = rem_n_q;
    rem_k_d    = rem_k_q;
    k_d        = k_q;
    n_d        = n_q;
    kt_nz_d    = kt_nz_q;
    addr_a_d   = addr_a_q;
    a_row_d    = a_row_q;
    addr_b_d   = addr_b_q;
    b_col_d    = b_col_q;
    b_base_d   = b_base_q;
    stride_b_d = stride_b_q;
    addr_d_d   = addr_d_q;
    c_run_d    = c_run_q;
    case (state_q)
      StIdle: begin
        if (job_valid) begin
          rem_m_d    = job_m;
          rem_n_d    = job_n;
          rem_k_d    = job_k;
          k_d        = job_k;
          n_d        = job_n;
          kt_nz_d    = 1'b0;
          addr_a_d   = job_addr_a;
          a_row_d    = job_addr_a;
          addr_b_d   = job_addr_b;
          b_col_d    = job_addr_b;
          b_base_d   = job_addr_b;
          stride_b_d = ADDR_WIDTH'(n_up);
          addr_d_d   = job_addr_d;
          c_run_d    = job_addr_c;
          // A degenerate job passes through DRAIN (nothing outstanding) so DONE lands 2 cycles on.
          if (job_m == '0 || job_k == '0 || job_n == '0) begin
            err_d   = 1'b1;
            state_d = StDrain;
          end else begin
            err_d   = 1'b0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (hs) begin
          if (!last_k) begin
            rem_k_d  = rem_k_q - W8;
            kt_nz_d  = 1'b1;
            addr_a_d = addr_a_q + WA;
            addr_b_d = addr_b_q + stride_b_q;
            state_d  = StWaitDep;
          end else if (!last_n) begin
            rem_k_d  = k_q;
            rem_n_d  = rem_n_q - W8;
            kt_nz_d  = 1'b0;
            addr_a_d = a_row_q;
            b_col_d  = b_col_q + WA;
            addr_b_d = b_col_q + WA;
            addr_d_d = addr_d_q + WA;
            c_run_d  = c_run_q + WA;
          end else if (!last_m) begin
            rem_k_d  = k_q;
            rem_n_d  = n_q;
            rem_m_d  = rem_m_q - W8;
            kt_nz_d  = 1'b0;
            a_row_d  = addr_a_q + WA;
            addr_a_d = addr_a_q + WA;
            b_col_d  = b_base_q;
            addr_b_d = b_base_q;
            addr_d_d = addr_d_q + WA;
            c_run_d  = c_run_q + WA;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StWaitDep: begin
        if (outst_d == '0) state_d = StIssue;
      end
      StDrain: begin
        if (outst_d == '0) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      err_q      <= 1'b0;
      rem_m_q    <= '0;
      rem_n_q    <= '0;
      rem_k_q    <= '0;
      k_q        <= '0;
      n_q        <= '0;
      kt_nz_q    <= 1'b0;
      addr_a_q   <= '0;
      a_row_q    <= '0;
      addr_b_q   <= '0;
      b_col_q    <= '0;
      b_base_q   <= '0;
      stride_b_q <= '0;
      addr_d_q   <= '0;
      c_run_q    <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      rem_m_q    <= rem_m_d;
      rem_n_q    <= rem_n_d;
      rem_k_q    <= rem_k_d;
      k_q        <= k_d;
      n_q        <= n_d;
      kt_nz_q    <= kt_nz_d;
      addr_a_q   <= addr_a_d;
      a_row_q    <= a_row_d;
      addr_b_q   <= addr_b_d;
      b_col_q    <= b_col_d;
      b_base_q   <= b_base_d;
      stride_b_q <= stride_b_d;
      addr_d_q   <= addr_d_d;
      c_run_q    <= c_run_d;
      outst_q    <= outst_d;
    end
  end

`ifdef TILE_SEQ_PERF_EN
  logic [31:0] stall_q;
  logic        stall_cyc;

  assign stall_cyc = (state_q == StWaitDep) || (state_q == StDrain) ||
                     ((state_q == StIssue) && !hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == StIdle && job_valid) begin
      stall_q <= '0;
    end else if (stall_cyc && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed, table-driven bench for gemm_tile_sequencer with a delayed tile_done responder.
module tb_gemm_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [7:0]  job_m, job_k, job_n;
  logic [9:0]  job_addr_a, job_addr_b, job_addr_c, job_addr_d;
  logic        cmd_valid, cmd_ready, tile_done;
  logic [63:0] cmd_data;
  logic        busy, job_done, job_err;
`ifdef TILE_SEQ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  gemm_tile_sequencer #(
    .ADDR_WIDTH(10),
    .SYSTOLIC_ARRAY_WIDTH(16),
    .OUTST_MAX(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_m(job_m),
    .job_k(job_k),
    .job_n(job_n),
    .job_addr_a(job_addr_a),
    .job_addr_b(job_addr_b),
    .job_addr_c(job_addr_c),
    .job_addr_d(job_addr_d),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .tile_done(tile_done),
    .busy(busy),
    .job_done(job_done),
    .job_err(job_err)
`ifdef TILE_SEQ_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [7:0] m, k, n;
    logic [9:0] a, b, c, d;
    int         ncmd;
    bit         err;
    int         base;
    int         hold;
  } job_t;

  typedef struct {
    logic [63:0] data;
    bit          dep;
  } exp_t;

  job_t jobs[8];
  exp_t exps[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] pk(int d, int c, int b, int a, int n, int k, int m);
    return {10'(d), 10'(c), 10'(b), 10'(a), 8'(n), 8'(k), 8'(m)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic setj(input int i, input int m, input int k, input int n, input int a,
                      input int b, input int c, input int d, input int ncmd, input bit err,
                      input int base, input int hold);
    jobs[i] = '{8'(m), 8'(k), 8'(n), 10'(a), 10'(b), 10'(c), 10'(d), ncmd, err, base, hold};
  endtask

  task automatic sete(input int i, input logic [63:0] data, input bit dep);
    exps[i] = '{data, dep};
  endtask

  // Called at a negedge; returns at the negedge after the job_done cycle.
  task automatic run_job(input int j);
    int cyc = 0;
    int ncmd = 0;
    int outst = 0;
    int last_td = -100;
    int first = -1;
    int q[$];
    bit fin = 1'b0;
    job_m      = jobs[j].m;
    job_k      = jobs[j].k;
    job_n      = jobs[j].n;
    job_addr_a = jobs[j].a;
    job_addr_b = jobs[j].b;
    job_addr_c = jobs[j].c;
    job_addr_d = jobs[j].d;
    job_valid  = 1'b1;
    cmd_ready  = (jobs[j].hold > 0) ? 1'b0 : 1'b1;
    tile_done  = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      job_valid = 1'b0;
      cmd_ready = (cyc <= jobs[j].hold) ? 1'b0 : 1'b1;
      if (cmd_valid && first < 0) first = cyc;
      if (cyc <= jobs[j].hold) begin
        check($sformatf("job%0d_hold_valid", j), 64'(cmd_valid), 64'd1);
        check($sformatf("job%0d_hold_data", j), cmd_data, exps[jobs[j].base].data);
      end
`ifdef TILE_SEQ_PERF_EN
      if (jobs[j].hold > 0 && cyc == jobs[j].hold + 1)
        check($sformatf("job%0d_stall_cycles", j), 64'(stall_cycles), 64'(jobs[j].hold));
`endif
      if (cmd_valid && cmd_ready) begin
        if (ncmd < jobs[j].ncmd) begin
          check($sformatf("job%0d_cmd%0d", j, ncmd), cmd_data, exps[jobs[j].base + ncmd].data);
          if (exps[jobs[j].base + ncmd].dep)
            check($sformatf("job%0d_cmd%0d_dep_outst", j, ncmd), 64'(outst), 64'd0);
        end else begin
          check($sformatf("job%0d_extra_cmd", j), 64'(ncmd + 1), 64'(jobs[j].ncmd));
        end
        ncmd++;
        outst++;
        q.push_back(cyc + 3);
      end
      if (job_done) begin
        fin = 1'b1;
        check($sformatf("job%0d_ncmd", j), 64'(ncmd), 64'(jobs[j].ncmd));
        check($sformatf("job%0d_err", j), 64'(job_err), 64'(jobs[j].err));
        if (jobs[j].err) check($sformatf("job%0d_err_latency", j), 64'(cyc), 64'd2);
        else check($sformatf("job%0d_done_latency", j), 64'(cyc - last_td), 64'd1);
        if (jobs[j].ncmd > 0) check($sformatf("job%0d_first_cmd", j), 64'(first), 64'd1);
      end
      tile_done = 1'b0;
      if (q.size() > 0 && q[0] <= cyc) begin
        void'(q.pop_front());
        tile_done = 1'b1;
        outst--;
        last_td = cyc;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL job%0d_timeout: got no job_done, expected job_done within 300 cycles", j);
    end
    @(negedge clk);
    tile_done = 1'b0;
    check($sformatf("job%0d_done_pulse", j), 64'({job_done, job_err, job_ready}), 64'b001);
  endtask

  initial begin
    int hs_cnt;
    setj(0, 16, 16, 16, 0, 40, 80, 120, 1, 1'b0, 0, 0);
    sete(0, pk(120, 80, 40, 0, 16, 16, 16), 1'b0);
    setj(1, 32, 16, 20, 0, 40, 80, 120, 4, 1'b0, 1, 0);
    sete(1, pk(120, 80, 40, 0, 16, 16, 16), 1'b0);
    sete(2, pk(136, 96, 56, 0, 4, 16, 16), 1'b0);
    sete(3, pk(152, 112, 40, 16, 16, 16, 16), 1'b0);
    sete(4, pk(168, 128, 56, 16, 4, 16, 16), 1'b0);
    setj(2, 16, 40, 16, 0, 40, 80, 120, 3, 1'b0, 5, 0);
    sete(5, pk(120, 80, 40, 0, 16, 16, 16), 1'b0);
    sete(6, pk(120, 120, 56, 16, 16, 16, 16), 1'b1);
    sete(7, pk(120, 120, 72, 32, 16, 8, 16), 1'b1);
    setj(3, 16, 0, 16, 0, 40, 80, 120, 0, 1'b1, 8, 0);
    setj(4, 20, 20, 16, 1000, 1016, 1020, 1008, 4, 1'b0, 8, 0);
    sete(8, pk(1008, 1020, 1016, 1000, 16, 16, 16), 1'b0);
    sete(9, pk(1008, 1008, 8, 1016, 16, 4, 16), 1'b1);
    sete(10, pk(0, 12, 1016, 8, 16, 16, 4), 1'b0);
    sete(11, pk(0, 0, 8, 24, 16, 4, 4), 1'b1);
    setj(5, 32, 16, 16, 5, 6, 7, 8, 2, 1'b0, 12, 10);
    sete(12, pk(8, 7, 6, 5, 16, 16, 16), 1'b0);
    sete(13, pk(24, 23, 6, 21, 16, 16, 16), 1'b0);
    setj(6, 16, 20, 20, 0, 100, 200, 300, 4, 1'b0, 14, 0);
    sete(14, pk(300, 200, 100, 0, 16, 16, 16), 1'b0);
    sete(15, pk(300, 300, 132, 16, 16, 4, 16), 1'b1);
    sete(16, pk(316, 216, 116, 0, 4, 16, 16), 1'b0);
    sete(17, pk(316, 316, 148, 16, 4, 4, 16), 1'b1);
    setj(7, 0, 5, 5, 1, 2, 3, 4, 0, 1'b1, 0, 0);

    rst = 1'b1;
    job_valid = 1'b0;
    job_m = '0; job_k = '0; job_n = '0;
    job_addr_a = '0; job_addr_b = '0; job_addr_c = '0; job_addr_d = '0;
    cmd_ready = 1'b1;
    tile_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({job_ready, cmd_valid, busy, job_done, job_err}), 64'b10000);
    check("reset_cmd_data", cmd_data, 64'd0);
`ifdef TILE_SEQ_PERF_EN
    check("reset_stall", 64'(stall_cycles), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 8; j++) run_job(j);

    // Ten independent tiles with tile_done withheld: issue must stop at 8 outstanding.
    job_m = 8'd16; job_k = 8'd16; job_n = 8'd160;
    job_addr_a = 10'd0; job_addr_b = 10'd0; job_addr_c = 10'd0; job_addr_d = 10'd0;
    job_valid = 1'b1;
    cmd_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      job_valid = 1'b0;
      if (cmd_valid && cmd_ready) hs_cnt++;
    end
    check("outst_max_issued", 64'(hs_cnt), 64'd8);
    check("outst_max_valid_low", 64'({cmd_valid, busy}), 64'b01);
    rst = 1'b1;
    @(negedge clk);
    check("midjob_reset", 64'({job_ready, busy, cmd_valid, job_done}), 64'b1000);
    rst = 1'b0;
    tile_done = 1'b1;  // stray done with nothing outstanding must not underflow
    @(negedge clk);
    tile_done = 1'b0;
    check("stray_done_idle", 64'({job_ready, busy, job_done}), 64'b100);
    run_job(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
